dispatcher: RTL and testbench
=============================

Name: dispatcher

Overview:
- Issue-side transmitter for the 16-entry reorder buffer.
- Pops one decoded instruction at a time from the instruction queue and resolves its source operands from the register file, the ROB, and same-cycle ALU/LSB broadcasts.
- Allocates the ROB entry and issues the instruction to the ROB plus either the RS (ALU ops) or the LSB (loads/stores).
- Drops any held instruction on a ROB clear.

Parameters:
- ROB_W, 4, ROB tag width (16 entries).
- OP_W, 6, opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; when low, all state holds.
- clear  in  1  ROB flush (mispredict).
- inst_valid  in  1  instruction-queue head valid.
- inst_opcode/inst_rd/inst_rs1/inst_rs2  in  6/5/5/5  decoded fields.
- inst_imm, inst_pc  in  32 each  immediate, instruction PC.
- inst_pred_br  in  1  fetch-predicted taken.
- inst_ready  out  1  pop strobe to the instruction queue.
- rf_rs1_id, rf_rs2_id  out  5 each  combinational regfile read addresses.
- rf_rs1_busy/rf_rs1_tag/rf_rs1_val, rf_rs2_*  in  1/4/32  regfile rename status.
- rob_q1_tag, rob_q2_tag  out  4 each  ROB peek addresses.
- rob_q1_rdy/rob_q1_val, rob_q2_*  in  1/32  ROB entry done and value.
- alu_upt_en/alu_upt_rob_id/alu_upt_val  in  1/4/32  ALU broadcast.
- lsb_upt_en/lsb_upt_rob_id/lsb_upt_val  in  1/4/32  LSB broadcast.
- rob_full, rob_free_id  in  1/4  ROB status and next tag.
- rs_full, lsb_full  in  1 each  target-queue full.
- issue_en, issue_opcode, issue_rd, issue_des_pc, issue_pre_br  out  1/6/5/32/1  ROB allocate.
- rs_issue_en, lsb_issue_en  out  1 each  target select.
- op_v1, op_v2  out  32 each  operand values.
- op_q1, op_q2  out  4 each  pending tags.
- op_r1, op_r2  out  1 each  operand ready.
- op_imm, op_rob_id  out  32/4  immediate, destination tag.
- rf_rename_en, rf_rename_rd, rf_rename_tag  out  1/5/4  rename write.

Behaviour:
- Reset: all outputs 0; state EMPTY; holding buffer invalid.
- States:
  - EMPTY: if inst_valid, latch the instruction, pulse inst_ready for that cycle, go to PENDING.
  - PENDING: go = !rob_full && !(is_mem ? lsb_full : rs_full). If go, all issue outputs are registered and valid for exactly one cycle after the go edge, and the tag is rob_free_id sampled at that edge.
  - PENDING, go, inst_valid: latch the next instruction and pulse inst_ready in the same cycle (back-to-back issue, one instruction per cycle); stay PENDING.
  - PENDING, go, no inst_valid: go to EMPTY.
  - PENDING, !go: hold the instruction and drive no issue pulses.
- Operand resolution is combinational in PENDING. Priority:
  1. rs==0: value 0, ready.
  2. !rf_busy: rf_val, ready.
  3. alu_upt_en and tag match: alu_upt_val, ready.
  4. lsb_upt_en and tag match: lsb_upt_val, ready.
  5. rob_q_rdy: rob_q_val, ready.
  6. Otherwise not ready, op_q = rf tag, op_v = 0.
- Ops without rs2 report op_r2 = 1 and op_v2 = 0.
- Rename:
  - rf_rename_en pulses with issue_en for ops that write rd with rd != 0.
  - Branches and stores: issue_rd = 0 and no rename.
- Self-dependency (rd == rs) resolves against pre-rename status, because the rename lands at the issue edge.
- clear (priority over everything, when rdy): invalidate the buffer, go to EMPTY, deassert inst_ready and all pulses next cycle, do not pop.
- rdy low: no state change; pulses already asserted are held unchanged.
- Tags wrap modulo 16 inside the ROB; the dispatcher never increments them.
- Async reset mid-PENDING: the instruction is lost and outputs go to 0 immediately.

Decomposition:
- Shared package cpu_defs holds:
  - opcode constants (OP_LUI..OP_AND);
  - class helpers is_mem, is_store, is_branch, writes_rd, uses_rs2;
  - ROB_W and OP_W;
  - a zero-tag constant.
- Sub-module operand_resolve: one instance per source, implementing the priority mux above. It is pure combinational logic and is reused by the LSB.

Test Plan:
- Reset -> issue_en, rs_issue_en, lsb_issue_en, inst_ready, rf_rename_en all 0 while rst=0 and one cycle after release.
- ADD x3,x1,x2; x1=5, x2=7 not busy; rob_free_id=4 -> one cycle after latch: issue_en=1, rs_issue_en=1, op_v1=5, op_v2=7, op_r1=op_r2=1, op_rob_id=4, rf_rename rd=3 tag=4.
- Same ADD with rob_full=1 for 3 cycles -> no pulses and inst_ready=0 for 3 cycles; issue occurs the cycle after rob_full drops.
- x1 busy tag 2, alu_upt_en=1, alu_upt_rob_id=2, alu_upt_val=0x55 on the go cycle -> op_v1=0x55, op_r1=1, op_q1 ignored.
- SW x5,8(x6), lsb_full=0 -> lsb_issue_en=1, rs_issue_en=0, issue_rd=0, rf_rename_en=0, op_imm=8.
- clear asserted while PENDING with rob_full=1 -> no issue ever occurs, state EMPTY, the next inst_valid is latched normally.

Source files
------------

// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants, opcode classes and dispatch types
package cpu_defs;

  localparam int ROB_W = 4;
  localparam int OP_W  = 6;

  localparam logic [ROB_W-1:0] ZERO_TAG = '0;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;

  typedef enum logic {ST_EMPTY, ST_PENDING} disp_state_e;

  typedef struct packed {
    logic [OP_W-1:0] opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [31:0]     pc;
    logic            pred_br;
  } inst_t;

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic writes_rd(input logic [OP_W-1:0] op);
    return !is_branch(op) && !is_store(op);
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return is_branch(op) || is_store(op) || ((op >= OP_ADD) && (op <= OP_AND));
  endfunction

endpackage

// File: rtl/operand_resolve.sv
// rtl/operand_resolve.sv - priority mux resolving one source operand
module operand_resolve
  import cpu_defs::*;
(
  input  logic [4:0]       rs,
  input  logic             rf_busy,
  input  logic [ROB_W-1:0] rf_tag,
  input  logic [31:0]      rf_val,
  input  logic             alu_en,
  input  logic [ROB_W-1:0] alu_id,
  input  logic [31:0]      alu_val,
  input  logic             lsb_en,
  input  logic [ROB_W-1:0] lsb_id,
  input  logic [31:0]      lsb_val,
  input  logic             rob_rdy,
  input  logic [31:0]      rob_val,
  output logic [31:0]      val,
  output logic [ROB_W-1:0] tag,
  output logic             ready
);

  always_comb begin
    val   = '0;
    tag   = ZERO_TAG;
    ready = 1'b1;
    if (rs == 5'd0) begin
      val = '0;
    end else if (!rf_busy) begin
      val = rf_val;
    end else if (alu_en && (alu_id == rf_tag)) begin
      val = alu_val;
    end else if (lsb_en && (lsb_id == rf_tag)) begin
      val = lsb_val;
    end else if (rob_rdy) begin
      val = rob_val;
    end else begin
      tag   = rf_tag;
      ready = 1'b0;
    end
  end

endmodule

// File: rtl/dispatcher.sv
// rtl/dispatcher.sv - issue-side transmitter from instruction queue to ROB/RS/LSB
module dispatcher
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              inst_valid,
  input  logic [OP_W-1:0]   inst_opcode,
  input  logic [4:0]        inst_rd,
  input  logic [4:0]        inst_rs1,
  input  logic [4:0]        inst_rs2,
  input  logic [31:0]       inst_imm,
  input  logic [31:0]       inst_pc,
  input  logic              inst_pred_br,
  output logic              inst_ready,
  output logic [4:0]        rf_rs1_id,
  output logic [4:0]        rf_rs2_id,
  input  logic              rf_rs1_busy,
  input  logic [ROB_W-1:0]  rf_rs1_tag,
  input  logic [31:0]       rf_rs1_val,
  input  logic              rf_rs2_busy,
  input  logic [ROB_W-1:0]  rf_rs2_tag,
  input  logic [31:0]       rf_rs2_val,
  output logic [ROB_W-1:0]  rob_q1_tag,
  output logic [ROB_W-1:0]  rob_q2_tag,
  input  logic              rob_q1_rdy,
  input  logic [31:0]       rob_q1_val,
  input  logic              rob_q2_rdy,
  input  logic [31:0]       rob_q2_val,
  input  logic              alu_upt_en,
  input  logic [ROB_W-1:0]  alu_upt_rob_id,
  input  logic [31:0]       alu_upt_val,
  input  logic              lsb_upt_en,
  input  logic [ROB_W-1:0]  lsb_upt_rob_id,
  input  logic [31:0]       lsb_upt_val,
  input  logic              rob_full,
  input  logic [ROB_W-1:0]  rob_free_id,
  input  logic              rs_full,
  input  logic              lsb_full,
  output logic              issue_en,
  output logic [OP_W-1:0]   issue_opcode,
  output logic [4:0]        issue_rd,
  output logic [31:0]       issue_des_pc,
  output logic              issue_pre_br,
  output logic              rs_issue_en,
  output logic              lsb_issue_en,
  output logic [31:0]       op_v1,
  output logic [31:0]       op_v2,
  output logic [ROB_W-1:0]  op_q1,
  output logic [ROB_W-1:0]  op_q2,
  output logic              op_r1,
  output logic              op_r2,
  output logic [31:0]       op_imm,
  output logic [ROB_W-1:0]  op_rob_id,
  output logic              rf_rename_en,
  output logic [4:0]        rf_rename_rd,
  output logic [ROB_W-1:0]  rf_rename_tag
);

  disp_state_e state;
  inst_t       held;

  logic             held_mem;
  logic             go;
  logic             pop;
  logic [31:0]      v1, v2, v2_raw;
  logic [ROB_W-1:0] q1, q2, q2_raw;
  logic             r1, r2, r2_raw;

  assign held_mem = is_mem(held.opcode);
  assign go  = rdy && !clear && (state == ST_PENDING) && !rob_full &&
               !(held_mem ? lsb_full : rs_full);
  // A slot frees up either when empty or when the held instruction leaves this edge.
  assign pop = rdy && !clear && inst_valid && ((state == ST_EMPTY) || go);
  assign inst_ready = rst && pop;

  assign rf_rs1_id  = held.rs1;
  assign rf_rs2_id  = held.rs2;
  assign rob_q1_tag = (state == ST_PENDING) ? rf_rs1_tag : ZERO_TAG;
  assign rob_q2_tag = (state == ST_PENDING) ? rf_rs2_tag : ZERO_TAG;

  operand_resolve u_rs1 (
    .rs(held.rs1), .rf_busy(rf_rs1_busy), .rf_tag(rf_rs1_tag), .rf_val(rf_rs1_val),
    .alu_en(alu_upt_en), .alu_id(alu_upt_rob_id), .alu_val(alu_upt_val),
    .lsb_en(lsb_upt_en), .lsb_id(lsb_upt_rob_id), .lsb_val(lsb_upt_val),
    .rob_rdy(rob_q1_rdy), .rob_val(rob_q1_val),
    .val(v1), .tag(q1), .ready(r1)
  );

  operand_resolve u_rs2 (
    .rs(held.rs2), .rf_busy(rf_rs2_busy), .rf_tag(rf_rs2_tag), .rf_val(rf_rs2_val),
    .alu_en(alu_upt_en), .alu_id(alu_upt_rob_id), .alu_val(alu_upt_val),
    .lsb_en(lsb_upt_en), .lsb_id(lsb_upt_rob_id), .lsb_val(lsb_upt_val),
    .rob_rdy(rob_q2_rdy), .rob_val(rob_q2_val),
    .val(v2_raw), .tag(q2_raw), .ready(r2_raw)
  );

  always_comb begin
    v2 = v2_raw;
    q2 = q2_raw;
    r2 = r2_raw;
    if (!uses_rs2(held.opcode)) begin
      v2 = '0;
      q2 = ZERO_TAG;
      r2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_EMPTY;
      held          <= '0;
      issue_en      <= 1'b0;
      issue_opcode  <= '0;
      issue_rd      <= '0;
      issue_des_pc  <= '0;
      issue_pre_br  <= 1'b0;
      rs_issue_en   <= 1'b0;
      lsb_issue_en  <= 1'b0;
      op_v1         <= '0;
      op_v2         <= '0;
      op_q1         <= ZERO_TAG;
      op_q2         <= ZERO_TAG;
      op_r1         <= 1'b0;
      op_r2         <= 1'b0;
      op_imm        <= '0;
      op_rob_id     <= ZERO_TAG;
      rf_rename_en  <= 1'b0;
      rf_rename_rd  <= '0;
      rf_rename_tag <= ZERO_TAG;
    end else if (rdy) begin
      if (clear) begin
        state        <= ST_EMPTY;
        issue_en     <= 1'b0;
        rs_issue_en  <= 1'b0;
        lsb_issue_en <= 1'b0;
        rf_rename_en <= 1'b0;
      end else begin
        issue_en     <= go;
        rs_issue_en  <= go && !held_mem;
        lsb_issue_en <= go && held_mem;
        rf_rename_en <= go && writes_rd(held.opcode) && (held.rd != 5'd0);
        if (go) begin
          issue_opcode  <= held.opcode;
          issue_rd      <= writes_rd(held.opcode) ? held.rd : 5'd0;
          issue_des_pc  <= held.pc;
          issue_pre_br  <= held.pred_br;
          op_v1         <= v1;
          op_v2         <= v2;
          op_q1         <= q1;
          op_q2         <= q2;
          op_r1         <= r1;
          op_r2         <= r2;
          op_imm        <= held.imm;
          op_rob_id     <= rob_free_id;
          rf_rename_rd  <= held.rd;
          rf_rename_tag <= rob_free_id;
        end
        if (pop) begin
          state        <= ST_PENDING;
          held.opcode  <= inst_opcode;
          held.rd      <= inst_rd;
          held.rs1     <= inst_rs1;
          held.rs2     <= inst_rs2;
          held.imm     <= inst_imm;
          held.pc      <= inst_pc;
          held.pred_br <= inst_pred_br;
        end else if (go) begin
          state <= ST_EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
// tb/tb_dispatcher.sv - randomized self-checking bench for dispatcher
module tb_dispatcher;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst, rdy, clear, inst_valid, inst_pred_br, inst_ready;
  logic [5:0] inst_opcode;
  logic [4:0] inst_rd, inst_rs1, inst_rs2, rf_rs1_id, rf_rs2_id;
  logic [31:0] inst_imm, inst_pc;
  logic rf_rs1_busy, rf_rs2_busy, rob_q1_rdy, rob_q2_rdy;
  logic [3:0] rf_rs1_tag, rf_rs2_tag, rob_q1_tag, rob_q2_tag;
  logic [31:0] rf_rs1_val, rf_rs2_val, rob_q1_val, rob_q2_val;
  logic alu_upt_en, lsb_upt_en, rob_full, rs_full, lsb_full;
  logic [3:0] alu_upt_rob_id, lsb_upt_rob_id, rob_free_id;
  logic [31:0] alu_upt_val, lsb_upt_val;
  logic issue_en, issue_pre_br, rs_issue_en, lsb_issue_en, op_r1, op_r2, rf_rename_en;
  logic [5:0] issue_opcode;
  logic [4:0] issue_rd, rf_rename_rd;
  logic [31:0] issue_des_pc, op_v1, op_v2, op_imm;
  logic [3:0] op_q1, op_q2, op_rob_id, rf_rename_tag;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit h_valid;
  logic [5:0] h_op;
  logic [4:0] h_rd, h_rs1, h_rs2;
  logic [31:0] h_imm, h_pc;
  logic h_pred;
  bit exp_pop, e_issue, e_rs, e_lsb, e_ren;
  logic [5:0] e_op;
  logic [4:0] e_rd, e_rrd;
  logic [31:0] e_pc, e_v1, e_v2, e_imm;
  logic e_pred, e_r1, e_r2;
  logic [3:0] e_q1, e_q2, e_id, e_rtag;

  always #5 clk = ~clk;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .inst_valid(inst_valid),
    .inst_opcode(inst_opcode), .inst_rd(inst_rd), .inst_rs1(inst_rs1), .inst_rs2(inst_rs2),
    .inst_imm(inst_imm), .inst_pc(inst_pc), .inst_pred_br(inst_pred_br), .inst_ready(inst_ready),
    .rf_rs1_id(rf_rs1_id), .rf_rs2_id(rf_rs2_id),
    .rf_rs1_busy(rf_rs1_busy), .rf_rs1_tag(rf_rs1_tag), .rf_rs1_val(rf_rs1_val),
    .rf_rs2_busy(rf_rs2_busy), .rf_rs2_tag(rf_rs2_tag), .rf_rs2_val(rf_rs2_val),
    .rob_q1_tag(rob_q1_tag), .rob_q2_tag(rob_q2_tag),
    .rob_q1_rdy(rob_q1_rdy), .rob_q1_val(rob_q1_val), .rob_q2_rdy(rob_q2_rdy), .rob_q2_val(rob_q2_val),
    .alu_upt_en(alu_upt_en), .alu_upt_rob_id(alu_upt_rob_id), .alu_upt_val(alu_upt_val),
    .lsb_upt_en(lsb_upt_en), .lsb_upt_rob_id(lsb_upt_rob_id), .lsb_upt_val(lsb_upt_val),
    .rob_full(rob_full), .rob_free_id(rob_free_id), .rs_full(rs_full), .lsb_full(lsb_full),
    .issue_en(issue_en), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
    .issue_des_pc(issue_des_pc), .issue_pre_br(issue_pre_br),
    .rs_issue_en(rs_issue_en), .lsb_issue_en(lsb_issue_en),
    .op_v1(op_v1), .op_v2(op_v2), .op_q1(op_q1), .op_q2(op_q2), .op_r1(op_r1), .op_r2(op_r2),
    .op_imm(op_imm), .op_rob_id(op_rob_id),
    .rf_rename_en(rf_rename_en), .rf_rename_rd(rf_rename_rd), .rf_rename_tag(rf_rename_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_is_mem(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit m_no_rd(input logic [5:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic bit m_has_rs2(input logic [5:0] op);
    return m_no_rd(op) || (op inside {OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
                                      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND});
  endfunction

  task automatic ref_operand(input logic [4:0] rs, input logic busy, input logic [3:0] tag,
                             input logic [31:0] rfv, input logic qrdy, input logic [31:0] qv,
                             output logic [31:0] v, output logic [3:0] q, output logic r);
    v = 32'd0; q = 4'd0; r = 1'b1;
    if (rs == 5'd0)                                    v = 32'd0;
    else if (!busy)                                    v = rfv;
    else if (alu_upt_en && alu_upt_rob_id == tag)      v = alu_upt_val;
    else if (lsb_upt_en && lsb_upt_rob_id == tag)      v = lsb_upt_val;
    else if (qrdy)                                     v = qv;
    else begin q = tag; r = 1'b0; end
  endtask

  task automatic model_reset();
    h_valid = 0; h_op = '0; h_rd = '0; h_rs1 = '0; h_rs2 = '0; h_imm = '0; h_pc = '0; h_pred = 0;
    exp_pop = 0; e_issue = 0; e_rs = 0; e_lsb = 0; e_ren = 0;
  endtask

  task automatic model_step();
    bit mem, can;
    exp_pop = 0;
    if (!rdy) return;
    if (clear) begin
      h_valid = 0; e_issue = 0; e_rs = 0; e_lsb = 0; e_ren = 0;
      return;
    end
    mem = m_is_mem(h_op);
    can = h_valid && !rob_full && !(mem ? lsb_full : rs_full);
    e_issue = can; e_rs = can && !mem; e_lsb = can && mem;
    e_ren = can && !m_no_rd(h_op) && (h_rd != 0);
    if (can) begin
      e_op = h_op; e_rd = m_no_rd(h_op) ? 5'd0 : h_rd; e_pc = h_pc; e_pred = h_pred;
      e_imm = h_imm; e_id = rob_free_id; e_rrd = h_rd; e_rtag = rob_free_id;
      ref_operand(h_rs1, rf_rs1_busy, rf_rs1_tag, rf_rs1_val, rob_q1_rdy, rob_q1_val, e_v1, e_q1, e_r1);
      ref_operand(h_rs2, rf_rs2_busy, rf_rs2_tag, rf_rs2_val, rob_q2_rdy, rob_q2_val, e_v2, e_q2, e_r2);
      if (!m_has_rs2(h_op)) begin e_v2 = 0; e_q2 = 0; e_r2 = 1; end
    end
    exp_pop = inst_valid && (!h_valid || can);
    if (exp_pop) begin
      h_valid = 1; h_op = inst_opcode; h_rd = inst_rd; h_rs1 = inst_rs1; h_rs2 = inst_rs2;
      h_imm = inst_imm; h_pc = inst_pc; h_pred = inst_pred_br;
    end else if (can) begin
      h_valid = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("issue_en", 32'(issue_en), 32'(e_issue));
    check_eq("rs_issue_en", 32'(rs_issue_en), 32'(e_rs));
    check_eq("lsb_issue_en", 32'(lsb_issue_en), 32'(e_lsb));
    check_eq("rf_rename_en", 32'(rf_rename_en), 32'(e_ren));
    if (e_issue) begin
      check_eq("issue_opcode", 32'(issue_opcode), 32'(e_op));
      check_eq("issue_rd", 32'(issue_rd), 32'(e_rd));
      check_eq("issue_des_pc", issue_des_pc, e_pc);
      check_eq("issue_pre_br", 32'(issue_pre_br), 32'(e_pred));
      check_eq("op_v1", op_v1, e_v1);
      check_eq("op_q1", 32'(op_q1), 32'(e_q1));
      check_eq("op_r1", 32'(op_r1), 32'(e_r1));
      check_eq("op_v2", op_v2, e_v2);
      check_eq("op_q2", 32'(op_q2), 32'(e_q2));
      check_eq("op_r2", 32'(op_r2), 32'(e_r2));
      check_eq("op_imm", op_imm, e_imm);
      check_eq("op_rob_id", 32'(op_rob_id), 32'(e_id));
    end
    if (e_ren) begin
      check_eq("rename_rd", 32'(rf_rename_rd), 32'(e_rrd));
      check_eq("rename_tag", 32'(rf_rename_tag), 32'(e_rtag));
    end
  endtask

  // Called just after a falling edge with inputs already driven for the coming rising edge.
  task automatic step();
    #1;
    if (h_valid) begin
      check_eq("rf_rs1_id", 32'(rf_rs1_id), 32'(h_rs1));
      check_eq("rf_rs2_id", 32'(rf_rs2_id), 32'(h_rs2));
      check_eq("rob_q1_tag", 32'(rob_q1_tag), 32'(rf_rs1_tag));
      check_eq("rob_q2_tag", 32'(rob_q2_tag), 32'(rf_rs2_tag));
    end
    model_step();
    check_eq("inst_ready", 32'(inst_ready), 32'(exp_pop));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic randomize_inputs();
    rdy = ($urandom_range(0, 99) < 88);
    clear = ($urandom_range(0, 99) < 5);
    inst_valid = 1'($urandom_range(0, 1));
    inst_opcode = 6'($urandom_range(1, 37));
    inst_rd = 5'($urandom_range(0, 7));
    inst_rs1 = 5'($urandom_range(0, 7));
    inst_rs2 = 5'($urandom_range(0, 7));
    inst_imm = $urandom; inst_pc = $urandom; inst_pred_br = 1'($urandom_range(0, 1));
    rf_rs1_busy = 1'($urandom_range(0, 1)); rf_rs1_tag = 4'($urandom_range(0, 3)); rf_rs1_val = $urandom;
    rf_rs2_busy = 1'($urandom_range(0, 1)); rf_rs2_tag = 4'($urandom_range(0, 3)); rf_rs2_val = $urandom;
    rob_q1_rdy = ($urandom_range(0, 99) < 30); rob_q1_val = $urandom;
    rob_q2_rdy = ($urandom_range(0, 99) < 30); rob_q2_val = $urandom;
    alu_upt_en = 1'($urandom_range(0, 1)); alu_upt_rob_id = 4'($urandom_range(0, 3)); alu_upt_val = $urandom;
    lsb_upt_en = 1'($urandom_range(0, 1)); lsb_upt_rob_id = 4'($urandom_range(0, 3)); lsb_upt_val = $urandom;
    rob_full = ($urandom_range(0, 99) < 25); rob_free_id = 4'($urandom_range(0, 15));
    rs_full = ($urandom_range(0, 99) < 20); lsb_full = ($urandom_range(0, 99) < 20);
  endtask

  task automatic quiet_inputs();
    rdy = 1; clear = 0; inst_valid = 0; inst_pred_br = 0;
    rf_rs1_busy = 0; rf_rs2_busy = 0; rob_q1_rdy = 0; rob_q2_rdy = 0;
    alu_upt_en = 0; lsb_upt_en = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
    rf_rs1_tag = 0; rf_rs2_tag = 0; alu_upt_rob_id = 0; lsb_upt_rob_id = 0; rob_free_id = 0;
    rf_rs1_val = 0; rf_rs2_val = 0; rob_q1_val = 0; rob_q2_val = 0; alu_upt_val = 0; lsb_upt_val = 0;
  endtask

  initial begin
    quiet_inputs();
    inst_opcode = OP_ADD; inst_rd = 5'd3; inst_rs1 = 5'd1; inst_rs2 = 5'd2;
    inst_imm = 32'd0; inst_pc = 32'h100;
    rst = 0;
    inst_valid = 1;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_inst_ready", 32'(inst_ready), 32'd0);
      check_eq("rst_issue_en", 32'(issue_en), 32'd0);
      check_eq("rst_rs_issue_en", 32'(rs_issue_en), 32'd0);
      check_eq("rst_lsb_issue_en", 32'(lsb_issue_en), 32'd0);
      check_eq("rst_rename_en", 32'(rf_rename_en), 32'd0);
    end
    rst = 1;
    inst_valid = 0;
    step();

    // ADD x3,x1,x2 with x1=5, x2=7 ready, free tag 4
    inst_valid = 1; rf_rs1_val = 32'd5; rf_rs2_val = 32'd7; rob_free_id = 4'd4;
    step();
    inst_valid = 0;
    step();
    check_eq("plan_v1", op_v1, 32'd5);
    check_eq("plan_v2", op_v2, 32'd7);
    check_eq("plan_rob_id", 32'(op_rob_id), 32'd4);
    check_eq("plan_rename_rd", 32'(rf_rename_rd), 32'd3);

    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step();
    end

    // back-to-back ALU issue, then async reset while a pulse is high
    quiet_inputs();
    inst_valid = 1; inst_opcode = OP_ADD; inst_rd = 5'd9;
    repeat (3) step();
    rst = 0;
    #1;
    check_eq("async_issue_en", 32'(issue_en), 32'd0);
    check_eq("async_rename_en", 32'(rf_rename_en), 32'd0);
    check_eq("async_inst_ready", 32'(inst_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    inst_valid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
